// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link: FSM state type, default frame
// geometry (also used by the transmit-side mux) and slot-counter sizing.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } tdm_state_t;

    localparam int TDM_N_CH = 4;
    localparam int TDM_W    = 8;

    // Slot counter width: clog2 of the channel count, never less than one bit.
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Receive-side TDM bus: slot words in, assembled frame and status out.
// The master end is the upstream source, the slave end is the demux.
interface tdm_demux_if
    import tdm_pkg::*;
#(
    parameter int N_CH = TDM_N_CH,
    parameter int W    = TDM_W
);

    logic [W-1:0]      din;
    logic              din_valid;
    logic              frame_sync;
    logic [N_CH*W-1:0] dout;
    logic              frame_valid;
    logic              locked;
    logic              sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  dout, frame_valid, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output dout, frame_valid, locked, sync_err
    );

endinterface

// File: rtl/tdm_demux_slot_dec.sv
// 1:N slot decoder: turns the target slot index into a one-hot write enable
// for the shadow registers. The last slot has no shadow (it goes straight to
// the output frame), so it decodes to all zeros.
module slot_dec #(
    parameter int N_CH = 4,
    parameter int SW   = 2
) (
    input  logic [SW-1:0]   slot,
    input  logic            en,
    output logic [N_CH-2:0] we
);

    // One-hot decode of the slot index, gated by the write enable.
    always_comb begin
        we = '0;
        for (int k = 0; k < N_CH - 1; k++) begin
            we[k] = en && (slot == SW'(k));
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: locks onto the frame-sync marker, steers each slot word
// into a shadow register and publishes a coherent frame on completion.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH = TDM_N_CH,
    parameter int W    = TDM_W
) (
    input  logic        clk,
    input  logic        rst_n,
    tdm_demux_if.slave  bus
);

    localparam int            SW   = slot_w(N_CH);
    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

    tdm_state_t     state, state_n;
    logic [SW-1:0]  slot, slot_n;
    logic [W-1:0]   shadow [N_CH-1];
    logic [SW-1:0]  wr_slot;
    logic           wr_en;
    logic [N_CH-2:0] shadow_we;
    logic           load_dout;
    logic           err_n;

    slot_dec #(
        .N_CH (N_CH),
        .SW   (SW)
    ) u_slot_dec (
        .slot (wr_slot),
        .en   (wr_en),
        .we   (shadow_we)
    );

    // Next-state, slot advance and shadow/output strobes for each valid beat.
    always_comb begin
        state_n   = state;
        slot_n    = slot;
        wr_slot   = slot;
        wr_en     = 1'b0;
        load_dout = 1'b0;
        err_n     = 1'b0;
        if (bus.din_valid) begin
            case (state)
                HUNT: begin
                    if (bus.frame_sync) begin
                        wr_en   = 1'b1;
                        wr_slot = '0;
                        slot_n  = SW'(1);
                        state_n = SYNC;
                    end
                end
                SYNC: begin
                    if (bus.frame_sync) begin
                        // A sync anywhere but slot 0 restarts the frame here.
                        wr_en   = 1'b1;
                        wr_slot = '0;
                        slot_n  = SW'(1);
                        err_n   = (slot != '0);
                    end else if (slot == '0) begin
                        err_n   = 1'b1;
                        state_n = HUNT;
                    end else if (slot == LAST) begin
                        load_dout = 1'b1;
                        slot_n    = '0;
                    end else begin
                        wr_en  = 1'b1;
                        slot_n = slot + SW'(1);
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // FSM state, slot counter and status pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= HUNT;
            slot            <= '0;
            bus.frame_valid <= 1'b0;
            bus.sync_err    <= 1'b0;
        end else begin
            state           <= state_n;
            slot            <= slot_n;
            bus.frame_valid <= load_dout;
            bus.sync_err    <= err_n;
        end
    end

    // Shadow registers collecting the partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH - 1; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH - 1; k++) begin
                if (shadow_we[k]) begin
                    shadow[k] <= bus.din;
                end
            end
        end
    end

    // Output frame: all shadows plus the final slot word, loaded together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout <= '0;
        end else if (load_dout) begin
            for (int k = 0; k < N_CH - 1; k++) begin
                bus.dout[k*W +: W] <= shadow[k];
            end
            bus.dout[(N_CH-1)*W +: W] <= bus.din;
        end
    end

    assign bus.locked = (state == SYNC);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N_CH=4, W=8) with a frame scoreboard.
module tb_tdm_demux;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int DW = N * W;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;
    int fv_count = 0;
    int err_count = 0;
    logic [DW-1:0] exp_q [$];

    tdm_demux_if #(.N_CH(N), .W(W)) bus ();

    tdm_demux #(.N_CH(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                               input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one valid beat for a cycle; returns just after the sampling edge.
    task automatic applyStimulus(input logic [W-1:0] d, input logic s);
        @(negedge clk);
        bus.din        = d;
        bus.din_valid  = 1'b1;
        bus.frame_sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.din_valid  = 1'b0;
            bus.frame_sync = 1'b0;
            bus.din        = W'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // Full 4-slot frame starting at base; expected result queued before the last beat.
    task automatic sendFrame(input logic [W-1:0] base, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) exp_q.push_back({base + W'(3), base + W'(2), base + W'(1), base});
            applyStimulus(base + W'(i), i == 0);
            if (gaps && i != N - 1) idle($urandom_range(0, 3));
        end
    endtask

    // Scoreboard side: each frame_valid cycle pops and compares one frame.
    always @(negedge clk) begin
        if (rst_n && bus.sync_err) err_count++;
        if (rst_n && bus.frame_valid) begin
            fv_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_frame", bus.dout, '0);
            end else begin
                checkOutput("frame_dout", bus.dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        int fv0, err0;
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.frame_sync = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_dout", bus.dout, '0);
        checkOutput("reset_fv", DW'(bus.frame_valid), '0);
        checkOutput("reset_locked", DW'(bus.locked), '0);
        checkOutput("reset_err", DW'(bus.sync_err), '0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset and hunt");
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        idle(1);
        checkOutput("hunt_locked", DW'(bus.locked), '0);
        checkOutput("hunt_dout", bus.dout, '0);
        checkOutput("hunt_fv_count", DW'(fv_count), '0);
        checkOutput("hunt_err_count", DW'(err_count), '0);

        $display("[TB] lock and frame");
        exp_q.push_back(32'hA3A2A1A0);
        applyStimulus(8'hA0, 1'b1);
        checkOutput("lock_rise", DW'(bus.locked), 1);
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'hA2, 1'b0);
        checkOutput("no_partial_dout", bus.dout, '0);
        applyStimulus(8'hA3, 1'b0);
        checkOutput("lock_fv_high", DW'(bus.frame_valid), 1);
        checkOutput("lock_dout", bus.dout, 32'hA3A2A1A0);
        idle(1);
        checkOutput("lock_fv_drop", DW'(bus.frame_valid), '0);
        checkOutput("lock_dout_hold", bus.dout, 32'hA3A2A1A0);

        $display("[TB] gaps and back-to-back");
        fv0 = fv_count;
        sendFrame(8'h10, 1'b1);
        checkOutput("gap_dout", bus.dout, 32'h13121110);
        sendFrame(8'h20, 1'b0);
        checkOutput("b2b_dout", bus.dout, 32'h23222120);
        checkOutput("b2b_fv_high", DW'(bus.frame_valid), 1);
        idle(2);
        checkOutput("b2b_fv_pulses", DW'(fv_count - fv0), 2);

        $display("[TB] early sync");
        fv0 = fv_count;
        err0 = err_count;
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h03, 1'b1);
        checkOutput("early_err", DW'(bus.sync_err), 1);
        checkOutput("early_locked", DW'(bus.locked), 1);
        exp_q.push_back(32'h06050403);
        applyStimulus(8'h04, 1'b0);
        checkOutput("early_err_drop", DW'(bus.sync_err), '0);
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h06, 1'b0);
        checkOutput("early_dout", bus.dout, 32'h06050403);
        idle(2);
        checkOutput("early_fv_pulses", DW'(fv_count - fv0), 1);
        checkOutput("early_err_pulses", DW'(err_count - err0), 1);

        $display("[TB] missing sync");
        sendFrame(8'hC0, 1'b0);
        err0 = err_count;
        applyStimulus(8'h55, 1'b0);
        checkOutput("miss_err", DW'(bus.sync_err), 1);
        checkOutput("miss_locked", DW'(bus.locked), '0);
        checkOutput("miss_dout", bus.dout, 32'hC3C2C1C0);
        idle(1);
        checkOutput("miss_err_drop", DW'(bus.sync_err), '0);
        checkOutput("miss_err_pulses", DW'(err_count - err0), 1);
        applyStimulus(8'h77, 1'b0);
        checkOutput("miss_still_hunting", DW'(bus.locked), '0);
        sendFrame(8'hD0, 1'b0);
        checkOutput("relock", DW'(bus.locked), 1);
        checkOutput("relock_dout", bus.dout, 32'hD3D2D1D0);
        idle(1);

        $display("[TB] reset mid-frame");
        fv0 = fv_count;
        applyStimulus(8'hE0, 1'b1);
        applyStimulus(8'hE1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_dout", bus.dout, '0);
        checkOutput("mid_rst_locked", DW'(bus.locked), '0);
        checkOutput("mid_rst_fv", DW'(bus.frame_valid), '0);
        bus.din_valid = 1'b0;
        bus.frame_sync = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sendFrame(8'hB0, 1'b0);
        checkOutput("post_rst_dout", bus.dout, 32'hB3B2B1B0);
        idle(2);
        checkOutput("post_rst_fv_pulses", DW'(fv_count - fv0), 1);
        checkOutput("queue_drained", DW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of a slot-multiplexed link where a 2:1/N:1 mux tree serialises N channels onto one shared bus. It locks onto a frame-sync marker, steers each incoming slot word to its channel register, and presents a complete, coherent N-channel frame with a one-cycle valid pulse. It sits downstream of the channel mux and feeds per-channel consumers.

## Interface
- `N_CH`, default 4: channels (slots) per frame; 2..16.
- `W`, default 8: data bits per slot.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in W: slot word on the shared bus.
- `din_valid` in 1: `din`/`frame_sync` meaningful this cycle; beats without it are ignored entirely.
- `frame_sync` in 1: qualified by `din_valid`; marks the beat as slot 0.
- `dout` out N_CH*W: last complete frame; channel k at bits [k*W +: W].
- `frame_valid` out 1: one-cycle pulse, new frame on `dout`.
- `locked` out 1: high in SYNC state.
- `sync_err` out 1: one-cycle pulse on framing violation.

## Operation
- States: HUNT (reset state), SYNC.
- Slot counter `slot`, width clog2(N_CH), reset 0. Shadow registers `shadow[0..N_CH-2]` (W each) hold the partial frame.
- HUNT:
  - Valid beat without sync is dropped.
  - Valid beat with sync stores to `shadow[0]`, sets `slot`=1, and moves to SYNC.
- SYNC, valid beat, slot==0:
  - Sync high: store `shadow[0]`, `slot`=1.
  - Sync low: `sync_err` pulse, beat dropped, go HUNT.
- SYNC, valid beat, 0<slot<N_CH-1:
  - Sync low: store `shadow[slot]`, `slot`++.
  - Sync high (early sync): `sync_err` pulse, partial frame discarded, beat treated as new slot 0 (`shadow[0]`, `slot`=1), stay SYNC.
- SYNC, valid beat, slot==N_CH-1:
  - Sync low: `dout` loads all shadows plus `din` as channel N_CH-1, `frame_valid` pulses, `slot` wraps to 0.
  - Sync high: handled as early sync, same as above.
- `dout` changes only on frame completion. Partial frames never reach `dout`.
- `locked` = (state==SYNC).
- Reset mid-frame clears state, counter, shadows and outputs. No frame is emitted.

## Timing
- Reset values: `dout`=0, `frame_valid`=0, `locked`=0, `sync_err`=0, state HUNT, `slot`=0.
- All outputs are registered.
- Latency: the edge sampling the last slot updates `dout` and raises `frame_valid` in the same edge. Both are visible for the following cycle. `frame_valid` drops on the next edge.
- `locked` rises on the edge sampling the first sync beat in HUNT. It falls on the edge sampling a missing-sync error.
- `sync_err` is high for exactly one cycle after the offending beat's edge.
- Gaps (`din_valid`=0) of any length between beats are allowed. Counter and shadows hold across gaps.
- Back-to-back frames at full rate: `frame_valid` may fire every N_CH cycles, with no dead cycles.

## Structure
- Shared package `tdm_pkg`:
  - state enum `tdm_state_t` {HUNT, SYNC};
  - function `slot_w(n)` = clog2(n), minimum 1;
  - default `N_CH`/`W` constants shared with the transmit-side mux.
- One sub-module `slot_dec`:
  - combinational;
  - `slot` plus enable → one-hot shadow write-enable vector (1:N demux).
- FSM, counter and `dout` capture live in `tdm_demux`.

## Test plan
All scenarios use N_CH=4, W=8.
- **Reset and hunt:** reset released, then valid beats 0x11, 0x22 without sync → `locked`=0, no `frame_valid`, no `sync_err`, `dout`=0.
- **Lock and frame:** beats 0xA0(sync), 0xA1, 0xA2, 0xA3 on consecutive cycles → `locked`=1 after the first beat. After the fourth beat, `dout`=0xA3A2A1A0 with a one-cycle `frame_valid`.
- **Gaps and back-to-back:** two frames 0x10..0x13 and 0x20..0x23, with random `din_valid` gaps inside the first and none inside the second → `dout`=0x13121110, then 0x23222120. Exactly two `frame_valid` pulses.
- **Early sync:** 0x01(sync), 0x02, then 0x03(sync), 0x04, 0x05, 0x06 → one `sync_err` pulse after the third beat and `locked` stays 1. The only frame output is `dout`=0x06050403.
- **Missing sync:** a full frame, then the next beat 0x55 without sync → `sync_err` pulse, `locked`=0, `dout` keeps the previous frame. A later sync beat re-locks.
- **Reset mid-frame:** assert `rst_n`=0 after 2 slots of a frame → all outputs return to 0 at once (asynchronously). After release, a fresh 4-slot frame is reported correctly.
